// File: rtl/lsu_mem_pkg.sv
// Shared CPU defines for the load/store unit: op codes, FSM states, byte-size masks
// and small decode helpers.
package lsu_mem_pkg;

    typedef enum logic [3:0] {
        OpNone = 4'd0,
        OpLdB  = 4'd1,
        OpLdH  = 4'd2,
        OpLdW  = 4'd3,
        OpLdBu = 4'd4,
        OpLdHu = 4'd5,
        OpStB  = 4'd6,
        OpStH  = 4'd7,
        OpStW  = 4'd8,
        OpLl   = 4'd9,
        OpSc   = 4'd10
    } lsu_op_e;

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StReq   = 2'd1,
        StWait  = 2'd2,
        StDrain = 2'd3
    } lsu_state_e;

    localparam logic [3:0] SizeMaskB = 4'h1;
    localparam logic [3:0] SizeMaskH = 4'h3;
    localparam logic [3:0] SizeMaskW = 4'hF;

    function automatic logic [3:0] op_size_mask(lsu_op_e op);
        case (op)
            OpLdB, OpLdBu, OpStB:    return SizeMaskB;
            OpLdH, OpLdHu, OpStH:    return SizeMaskH;
            OpLdW, OpStW, OpLl, OpSc: return SizeMaskW;
            default:                 return 4'h0;
        endcase
    endfunction

    // SC counts as a store: it writes memory when it succeeds.
    function automatic logic op_is_store(lsu_op_e op);
        return (op == OpStB) || (op == OpStH) || (op == OpStW) || (op == OpSc);
    endfunction

    function automatic logic op_misaligned(lsu_op_e op, logic [1:0] addr_lo);
        case (op)
            OpLdH, OpLdHu, OpStH:     return addr_lo[0];
            OpLdW, OpStW, OpLl, OpSc: return addr_lo != 2'b00;
            default:                  return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/lsu_mem_if.sv
// Memory bus between the LSU (master) and the data memory (slave): one request
// channel with ready/valid and a single-beat response per accepted request.
interface lsu_mem_if #(
    parameter int unsigned DATA_WIDTH = 32
) ();
    localparam int unsigned STRB_WIDTH = DATA_WIDTH / 8;

    logic                  req_valid;
    logic                  req_ready;
    logic                  req_we;
    logic [31:0]           req_addr;
    logic [STRB_WIDTH-1:0] req_strb;
    logic [DATA_WIDTH-1:0] req_wdata;
    logic                  resp_valid;
    logic [DATA_WIDTH-1:0] resp_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_strb, req_wdata,
        input  req_ready, resp_valid, resp_rdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_strb, req_wdata,
        output req_ready, resp_valid, resp_rdata
    );
endinterface

// File: rtl/lsu_load_align.sv
// Picks the addressed lane out of a bus read beat and sign/zero-extends it to 32 bits.
module lsu_load_align
    import lsu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0]           rdata_i,
    input  logic [$clog2(DATA_WIDTH/8)-1:0] offset_i,
    input  lsu_op_e                         op_i,
    output logic [31:0]                     result_o
);

    logic [DATA_WIDTH-1:0] lane;

    assign lane = rdata_i >> {offset_i, 3'b000};

    always_comb begin
        result_o = lane[31:0];
        case (op_i)
            OpLdB:   result_o = {{24{lane[7]}}, lane[7:0]};
            OpLdBu:  result_o = {24'h0, lane[7:0]};
            OpLdH:   result_o = {{16{lane[15]}}, lane[15:0]};
            OpLdHu:  result_o = {16'h0, lane[15:0]};
            default: result_o = lane[31:0];
        endcase
    end

endmodule

// File: rtl/lsu_mem.sv
// Load/store unit MEM stage: EX-side accept, one bus transaction per memory op,
// LL/SC reservation bit, and a held WB result register.
module lsu_mem
    import lsu_mem_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned STRB_WIDTH = DATA_WIDTH / 8
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        in_valid_i,
    output logic        in_ready_o,
    input  lsu_op_e     in_op_i,
    input  logic [31:0] in_addr_i,
    input  logic [31:0] in_wdata_i,
    input  logic [31:0] in_alu_res_i,
    input  logic [31:0] in_pc_i,
    input  logic [4:0]  in_wd_i,
    input  logic        in_wreg_i,
    input  logic        flush_i,
    input  logic        llbit_clr_i,
    output logic        out_valid_o,
    input  logic        out_ready_i,
    output logic [4:0]  out_wd_o,
    output logic        out_wreg_o,
    output logic [31:0] out_wdata_o,
    output logic [31:0] out_pc_o,
    output logic        out_ale_o,
    output logic [31:0] out_badv_o,
    lsu_mem_if.master   mem_bus
);

    localparam int unsigned OffW = $clog2(STRB_WIDTH);

    lsu_state_e            state_q, state_d;
    logic                  llbit_q, llbit_d;
    lsu_op_e               op_q, op_d;
    logic [OffW-1:0]       off_q, off_d;
    logic [4:0]            wd_q, wd_d;
    logic                  wreg_q, wreg_d;
    logic [31:0]           pc_q, pc_d;

    logic                  out_valid_q, out_valid_d;
    logic [4:0]            out_wd_q, out_wd_d;
    logic                  out_wreg_q, out_wreg_d;
    logic [31:0]           out_wdata_q, out_wdata_d;
    logic [31:0]           out_pc_q, out_pc_d;
    logic                  out_ale_q, out_ale_d;
    logic [31:0]           out_badv_q, out_badv_d;

    logic                  req_we_q, req_we_d;
    logic [31:0]           req_addr_q, req_addr_d;
    logic [STRB_WIDTH-1:0] req_strb_q, req_strb_d;
    logic [DATA_WIDTH-1:0] req_wdata_q, req_wdata_d;

    logic                  accept;
    logic                  misaligned;
    logic                  sc_fail;
    logic [3:0]            size_mask;
    logic [OffW-1:0]       in_off;
    logic [DATA_WIDTH-1:0] wdata_rep;
    logic [31:0]           load_res;

    assign in_ready_o = rst_ni && (state_q == StIdle) && (!out_valid_q || out_ready_i);
    // A flushed instruction is never taken, even if it coincides with in_ready.
    assign accept     = in_valid_i && in_ready_o && !flush_i;
    assign misaligned = op_misaligned(in_op_i, in_addr_i[1:0]);
    assign sc_fail    = (in_op_i == OpSc) && !llbit_q;
    assign size_mask  = op_size_mask(in_op_i);
    assign in_off     = in_addr_i[OffW-1:0];

    always_comb begin
        case (size_mask)
            SizeMaskB: wdata_rep = {STRB_WIDTH{in_wdata_i[7:0]}};
            SizeMaskH: wdata_rep = {(STRB_WIDTH/2){in_wdata_i[15:0]}};
            default:   wdata_rep = {(DATA_WIDTH/32){in_wdata_i}};
        endcase
    end

    lsu_load_align #(
        .DATA_WIDTH (DATA_WIDTH)
    ) u_load_align (
        .rdata_i  (mem_bus.resp_rdata),
        .offset_i (off_q),
        .op_i     (op_q),
        .result_o (load_res)
    );

    always_comb begin
        state_d     = state_q;
        llbit_d     = llbit_q;
        op_d        = op_q;
        off_d       = off_q;
        wd_d        = wd_q;
        wreg_d      = wreg_q;
        pc_d        = pc_q;
        out_valid_d = out_valid_q && !out_ready_i;
        out_wd_d    = out_wd_q;
        out_wreg_d  = out_wreg_q;
        out_wdata_d = out_wdata_q;
        out_pc_d    = out_pc_q;
        out_ale_d   = out_ale_q;
        out_badv_d  = out_badv_q;
        req_we_d    = req_we_q;
        req_addr_d  = req_addr_q;
        req_strb_d  = req_strb_q;
        req_wdata_d = req_wdata_q;

        case (state_q)
            StIdle: begin
                if (accept) begin
                    if (misaligned) begin
                        out_valid_d = 1'b1;
                        out_ale_d   = 1'b1;
                        out_badv_d  = in_addr_i;
                        out_wreg_d  = 1'b0;
                        out_wd_d    = in_wd_i;
                        out_wdata_d = 32'h0;
                        out_pc_d    = in_pc_i;
                    end else if ((in_op_i == OpNone) || sc_fail) begin
                        out_valid_d = 1'b1;
                        out_ale_d   = 1'b0;
                        out_badv_d  = 32'h0;
                        out_wreg_d  = in_wreg_i;
                        out_wd_d    = in_wd_i;
                        out_wdata_d = (in_op_i == OpNone) ? in_alu_res_i : 32'h0;
                        out_pc_d    = in_pc_i;
                    end else begin
                        state_d     = StReq;
                        op_d        = in_op_i;
                        off_d       = in_off;
                        wd_d        = in_wd_i;
                        wreg_d      = in_wreg_i;
                        pc_d        = in_pc_i;
                        req_we_d    = op_is_store(in_op_i);
                        req_addr_d  = {in_addr_i[31:OffW], {OffW{1'b0}}};
                        req_strb_d  = STRB_WIDTH'(size_mask) << in_off;
                        req_wdata_d = op_is_store(in_op_i) ? wdata_rep : '0;
                    end
                end
            end
            StReq: begin
                if (flush_i) begin
                    state_d = mem_bus.req_ready ? StDrain : StIdle;
                end else if (mem_bus.req_ready) begin
                    state_d = StWait;
                end
            end
            StWait: begin
                if (mem_bus.resp_valid) begin
                    state_d = StIdle;
                    if (!flush_i) begin
                        out_valid_d = 1'b1;
                        out_ale_d   = 1'b0;
                        out_badv_d  = 32'h0;
                        out_wd_d    = wd_q;
                        out_pc_d    = pc_q;
                        out_wreg_d  = (op_is_store(op_q) && (op_q != OpSc)) ? 1'b0 : wreg_q;
                        if (op_q == OpSc) begin
                            out_wdata_d = 32'h1;
                            llbit_d     = 1'b0;
                        end else if (op_is_store(op_q)) begin
                            out_wdata_d = 32'h0;
                        end else begin
                            out_wdata_d = load_res;
                            if (op_q == OpLl) llbit_d = 1'b1;
                        end
                    end
                end else if (flush_i) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (mem_bus.resp_valid) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase

        if (flush_i) out_valid_d = 1'b0;
        if (llbit_clr_i) llbit_d = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            llbit_q     <= 1'b0;
            op_q        <= OpNone;
            off_q       <= '0;
            wd_q        <= 5'h0;
            wreg_q      <= 1'b0;
            pc_q        <= 32'h0;
            out_valid_q <= 1'b0;
            out_wd_q    <= 5'h0;
            out_wreg_q  <= 1'b0;
            out_wdata_q <= 32'h0;
            out_pc_q    <= 32'h0;
            out_ale_q   <= 1'b0;
            out_badv_q  <= 32'h0;
            req_we_q    <= 1'b0;
            req_addr_q  <= 32'h0;
            req_strb_q  <= '0;
            req_wdata_q <= '0;
        end else begin
            state_q     <= state_d;
            llbit_q     <= llbit_d;
            op_q        <= op_d;
            off_q       <= off_d;
            wd_q        <= wd_d;
            wreg_q      <= wreg_d;
            pc_q        <= pc_d;
            out_valid_q <= out_valid_d;
            out_wd_q    <= out_wd_d;
            out_wreg_q  <= out_wreg_d;
            out_wdata_q <= out_wdata_d;
            out_pc_q    <= out_pc_d;
            out_ale_q   <= out_ale_d;
            out_badv_q  <= out_badv_d;
            req_we_q    <= req_we_d;
            req_addr_q  <= req_addr_d;
            req_strb_q  <= req_strb_d;
            req_wdata_q <= req_wdata_d;
        end
    end

    assign mem_bus.req_valid = (state_q == StReq);
    assign mem_bus.req_we    = req_we_q;
    assign mem_bus.req_addr  = req_addr_q;
    assign mem_bus.req_strb  = req_strb_q;
    assign mem_bus.req_wdata = req_wdata_q;

    assign out_valid_o = out_valid_q;
    assign out_wd_o    = out_wd_q;
    assign out_wreg_o  = out_wreg_q;
    assign out_wdata_o = out_wdata_q;
    assign out_pc_o    = out_pc_q;
    assign out_ale_o   = out_ale_q;
    assign out_badv_o  = out_badv_q;

endmodule

// File: tb/tb_lsu_mem.sv
// Directed bench for lsu_mem: a 32-bit instance for most scenarios and a 64-bit
// instance for wide-lane store replication and load selection.
module tb_lsu_mem;
    import lsu_mem_pkg::*;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // 32-bit instance
    logic        in_valid, in_ready, in_wreg, flush, llbit_clr, out_ready;
    lsu_op_e     in_op;
    logic [31:0] in_addr, in_wdata, in_alu_res, in_pc;
    logic [4:0]  in_wd;
    logic        out_valid, out_wreg, out_ale;
    logic [4:0]  out_wd;
    logic [31:0] out_wdata, out_pc, out_badv;
    lsu_mem_if #(.DATA_WIDTH(32)) bus32 ();

    lsu_mem #(.DATA_WIDTH(32)) dut32 (
        .clk_i (clk), .rst_ni (rst_n),
        .in_valid_i (in_valid), .in_ready_o (in_ready), .in_op_i (in_op),
        .in_addr_i (in_addr), .in_wdata_i (in_wdata), .in_alu_res_i (in_alu_res),
        .in_pc_i (in_pc), .in_wd_i (in_wd), .in_wreg_i (in_wreg),
        .flush_i (flush), .llbit_clr_i (llbit_clr),
        .out_valid_o (out_valid), .out_ready_i (out_ready), .out_wd_o (out_wd),
        .out_wreg_o (out_wreg), .out_wdata_o (out_wdata), .out_pc_o (out_pc),
        .out_ale_o (out_ale), .out_badv_o (out_badv), .mem_bus (bus32)
    );

    // 64-bit instance
    logic        v64, rdy64, ov64, owreg64, oale64;
    lsu_op_e     op64;
    logic [31:0] a64, d64, owdata64, opc64, obadv64;
    logic [4:0]  owd64;
    lsu_mem_if #(.DATA_WIDTH(64)) bus64 ();

    lsu_mem #(.DATA_WIDTH(64)) dut64 (
        .clk_i (clk), .rst_ni (rst_n),
        .in_valid_i (v64), .in_ready_o (rdy64), .in_op_i (op64),
        .in_addr_i (a64), .in_wdata_i (d64), .in_alu_res_i (32'h0),
        .in_pc_i (32'h100), .in_wd_i (5'd7), .in_wreg_i (1'b1),
        .flush_i (1'b0), .llbit_clr_i (1'b0),
        .out_valid_o (ov64), .out_ready_i (1'b1), .out_wd_o (owd64),
        .out_wreg_o (owreg64), .out_wdata_o (owdata64), .out_pc_o (opc64),
        .out_ale_o (oale64), .out_badv_o (obadv64), .mem_bus (bus64)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input lsu_op_e op, input logic [31:0] addr, input logic [31:0] wd,
                         input logic [31:0] alu);
        in_valid   = 1'b1;
        in_op      = op;
        in_addr    = addr;
        in_wdata   = wd;
        in_alu_res = alu;
        in_pc      = 32'h8000 + addr;
        tick();
        in_valid   = 1'b0;
    endtask

    // Request handshake (req_ready assumed high) then one response beat.
    task automatic mem_cycle(input logic [31:0] rdata);
        tick();
        bus32.resp_valid = 1'b1;
        bus32.resp_rdata = rdata;
        tick();
        bus32.resp_valid = 1'b0;
    endtask

    task automatic do_load(input string tag, input lsu_op_e op, input logic [31:0] addr,
                           input logic [31:0] rdata, input logic [3:0] strb,
                           input logic [31:0] exp);
        chk({tag, "_in_ready"}, 64'(in_ready), 64'h1);
        issue(op, addr, 32'h0, 32'h0);
        chk({tag, "_req_valid"}, 64'(bus32.req_valid), 64'h1);
        chk({tag, "_req_strb"}, 64'(bus32.req_strb), 64'(strb));
        chk({tag, "_req_addr"}, 64'(bus32.req_addr), 64'({addr[31:2], 2'b00}));
        mem_cycle(rdata);
        chk({tag, "_out_valid"}, 64'(out_valid), 64'h1);
        chk({tag, "_out_wdata"}, 64'(out_wdata), 64'(exp));
        chk({tag, "_out_wreg"}, 64'(out_wreg), 64'h1);
    endtask

    initial begin
        rst_n = 1'b0;
        in_valid = 1'b0; in_op = OpNone; in_addr = 32'h0; in_wdata = 32'h0;
        in_alu_res = 32'h0; in_pc = 32'h0; in_wd = 5'd3; in_wreg = 1'b1;
        flush = 1'b0; llbit_clr = 1'b0; out_ready = 1'b1;
        bus32.req_ready = 1'b1; bus32.resp_valid = 1'b0; bus32.resp_rdata = 32'h0;
        v64 = 1'b0; op64 = OpNone; a64 = 32'h0; d64 = 32'h0;
        bus64.req_ready = 1'b1; bus64.resp_valid = 1'b0; bus64.resp_rdata = 64'h0;

        tick();
        tick();
        chk("rst_in_ready", 64'(in_ready), 64'h0);
        chk("rst_out_valid", 64'(out_valid), 64'h0);
        chk("rst_req_valid", 64'(bus32.req_valid), 64'h0);
        chk("rst_out_wdata", 64'(out_wdata), 64'h0);
        rst_n = 1'b1;
        #1;
        chk("idle_in_ready", 64'(in_ready), 64'h1);

        // Byte/half/word lane selection and extension
        do_load("ldb", OpLdB, 32'h1003, 32'h80FF_0000, 4'b1000, 32'hFFFF_FF80);
        chk("ldb_out_pc", 64'(out_pc), 64'h9003);
        chk("ldb_out_wd", 64'(out_wd), 64'h3);
        do_load("ldhu", OpLdHu, 32'h1002, 32'h80FF_1234, 4'b1100, 32'h0000_80FF);
        do_load("ldh", OpLdH, 32'h1002, 32'h80FF_1234, 4'b1100, 32'hFFFF_80FF);
        do_load("ldbu", OpLdBu, 32'h1001, 32'h80FF_1234, 4'b0010, 32'h0000_0012);
        do_load("ldw", OpLdW, 32'h1004, 32'hDEAD_BEEF, 4'b1111, 32'hDEAD_BEEF);

        // Misaligned word load: no request, exception result next cycle
        issue(OpLdW, 32'h3002, 32'h0, 32'h0);
        chk("ale_req_valid", 64'(bus32.req_valid), 64'h0);
        chk("ale_out_valid", 64'(out_valid), 64'h1);
        chk("ale_flag", 64'(out_ale), 64'h1);
        chk("ale_badv", 64'(out_badv), 64'h3002);
        chk("ale_wreg", 64'(out_wreg), 64'h0);
        tick();
        chk("ale_done", 64'(out_valid), 64'h0);

        // NONE result held while WB stalls
        out_ready = 1'b0;
        issue(OpNone, 32'h0, 32'h0, 32'h0000_CAFE);
        for (int i = 0; i < 3; i++) begin
            chk("hold_valid", 64'(out_valid), 64'h1);
            chk("hold_wdata", 64'(out_wdata), 64'hCAFE);
            chk("hold_in_ready", 64'(in_ready), 64'h0);
            tick();
        end
        out_ready = 1'b1;
        #1;
        chk("release_in_ready", 64'(in_ready), 64'h1);
        tick();
        chk("release_valid", 64'(out_valid), 64'h0);

        // LL then SC succeeds, second SC fails without a request
        issue(OpLl, 32'h4000, 32'h0, 32'h0);
        chk("ll_req_we", 64'(bus32.req_we), 64'h0);
        mem_cycle(32'h1122_3344);
        chk("ll_wdata", 64'(out_wdata), 64'h1122_3344);
        issue(OpSc, 32'h4000, 32'h5, 32'h0);
        chk("sc_req_valid", 64'(bus32.req_valid), 64'h1);
        chk("sc_req_we", 64'(bus32.req_we), 64'h1);
        chk("sc_req_wdata", 64'(bus32.req_wdata), 64'h5);
        mem_cycle(32'h0);
        chk("sc_ok_wdata", 64'(out_wdata), 64'h1);
        chk("sc_ok_wreg", 64'(out_wreg), 64'h1);
        issue(OpSc, 32'h4000, 32'h5, 32'h0);
        chk("sc2_req_valid", 64'(bus32.req_valid), 64'h0);
        chk("sc2_out_valid", 64'(out_valid), 64'h1);
        chk("sc2_wdata", 64'(out_wdata), 64'h0);

        // Store between LL and SC keeps the reservation; byte replicated on all lanes
        issue(OpLl, 32'h4000, 32'h0, 32'h0);
        mem_cycle(32'h0);
        issue(OpStB, 32'h4001, 32'h0000_00A5, 32'h0);
        chk("stb_strb", 64'(bus32.req_strb), 64'h2);
        chk("stb_wdata", 64'(bus32.req_wdata), 64'hA5A5_A5A5);
        mem_cycle(32'h0);
        chk("stb_wreg", 64'(out_wreg), 64'h0);
        issue(OpSc, 32'h4000, 32'h7, 32'h0);
        mem_cycle(32'h0);
        chk("sc_after_st", 64'(out_wdata), 64'h1);

        // llbit_clr beats a simultaneous LL set
        issue(OpLl, 32'h4000, 32'h0, 32'h0);
        tick();
        bus32.resp_valid = 1'b1;
        llbit_clr = 1'b1;
        tick();
        bus32.resp_valid = 1'b0;
        llbit_clr = 1'b0;
        issue(OpSc, 32'h4000, 32'h7, 32'h0);
        chk("clr_sc_req", 64'(bus32.req_valid), 64'h0);
        chk("clr_sc_wdata", 64'(out_wdata), 64'h0);

        // Stalled request stays stable, then flush in WAIT drains one response
        bus32.req_ready = 1'b0;
        issue(OpLl, 32'h5000, 32'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            chk("stall_req_valid", 64'(bus32.req_valid), 64'h1);
            chk("stall_req_addr", 64'(bus32.req_addr), 64'h5000);
            chk("stall_req_strb", 64'(bus32.req_strb), 64'hF);
            tick();
        end
        bus32.req_ready = 1'b1;
        tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        chk("drain_in_ready", 64'(in_ready), 64'h0);
        chk("drain_req_valid", 64'(bus32.req_valid), 64'h0);
        bus32.resp_valid = 1'b1;
        bus32.resp_rdata = 32'h1234_5678;
        tick();
        bus32.resp_valid = 1'b0;
        chk("drain_out_valid", 64'(out_valid), 64'h0);
        chk("drain_done_ready", 64'(in_ready), 64'h1);
        issue(OpSc, 32'h5000, 32'h9, 32'h0);
        chk("drain_llbit_sc", 64'(out_wdata), 64'h0);
        chk("drain_llbit_req", 64'(bus32.req_valid), 64'h0);

        // Flush in REQ before handshake withdraws the request
        bus32.req_ready = 1'b0;
        issue(OpLdW, 32'h5004, 32'h0, 32'h0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        bus32.req_ready = 1'b1;
        chk("reqflush_valid", 64'(bus32.req_valid), 64'h0);
        chk("reqflush_ready", 64'(in_ready), 64'h1);

        // Flush in IDLE clears a pending result
        out_ready = 1'b0;
        issue(OpNone, 32'h0, 32'h0, 32'h55);
        chk("idleflush_pre", 64'(out_valid), 64'h1);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        out_ready = 1'b1;
        chk("idleflush_post", 64'(out_valid), 64'h0);

        // 64-bit bus: half store replication and upper-word load
        chk("w64_ready", 64'(rdy64), 64'h1);
        v64 = 1'b1; op64 = OpStH; a64 = 32'h2006; d64 = 32'h0000_BEEF;
        tick();
        v64 = 1'b0;
        chk("w64_req_valid", 64'(bus64.req_valid), 64'h1);
        chk("w64_req_addr", 64'(bus64.req_addr), 64'h2000);
        chk("w64_req_strb", 64'(bus64.req_strb), 64'hC0);
        chk("w64_req_wdata", bus64.req_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
        chk("w64_req_we", 64'(bus64.req_we), 64'h1);
        tick();
        bus64.resp_valid = 1'b1;
        tick();
        bus64.resp_valid = 1'b0;
        chk("w64_out_valid", 64'(ov64), 64'h1);
        chk("w64_out_wreg", 64'(owreg64), 64'h0);
        v64 = 1'b1; op64 = OpLdW; a64 = 32'h2004;
        tick();
        v64 = 1'b0;
        chk("w64_ld_strb", 64'(bus64.req_strb), 64'hF0);
        tick();
        bus64.resp_valid = 1'b1;
        bus64.resp_rdata = 64'h1122_3344_5566_7788;
        tick();
        bus64.resp_valid = 1'b0;
        chk("w64_ld_wdata", 64'(owdata64), 64'h1122_3344);

        // Asynchronous reset in the middle of WAIT
        issue(OpStW, 32'h6000, 32'hFFFF_FFFF, 32'h0);
        tick();
        rst_n = 1'b0;
        #1;
        chk("mrst_in_ready", 64'(in_ready), 64'h0);
        chk("mrst_out_valid", 64'(out_valid), 64'h0);
        chk("mrst_out_ale", 64'(out_ale), 64'h0);
        chk("mrst_out_wreg", 64'(out_wreg), 64'h0);
        chk("mrst_out_wd", 64'(out_wd), 64'h0);
        chk("mrst_out_wdata", 64'(out_wdata), 64'h0);
        chk("mrst_out_pc", 64'(out_pc), 64'h0);
        chk("mrst_out_badv", 64'(out_badv), 64'h0);
        chk("mrst_req_valid", 64'(bus32.req_valid), 64'h0);
        chk("mrst_req_we", 64'(bus32.req_we), 64'h0);
        chk("mrst_req_strb", 64'(bus32.req_strb), 64'h0);
        chk("mrst_req_addr", 64'(bus32.req_addr), 64'h0);
        chk("mrst_req_wdata", 64'(bus32.req_wdata), 64'h0);
        tick();
        rst_n = 1'b1;
        #1;
        chk("mrst_idle_ready", 64'(in_ready), 64'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
